// File: rtl/alu_4bit_sequencer_pkg.sv
// alu_seq_pkg: shared state encoding, flag bit positions and widths for the ALU sequencer
package alu_seq_pkg;
    localparam int OP_W = 4;
    localparam int D_W  = 4;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_P = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } seq_state_t;
endpackage

// File: rtl/alu_4bit_sequencer_if.sv
// alu_4bit_sequencer_if: request, ALU and result buses of the sequencer (sticky ports with ALU_SEQ_STICKY_FLAGS_EN)
interface alu_4bit_sequencer_if;
    import alu_seq_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] in_opcode;
    logic [D_W-1:0]  in_a;
    logic [D_W-1:0]  in_b;
    logic            in_use_acc;
    logic [D_W-1:0]  alu_a;
    logic [D_W-1:0]  alu_b;
    logic [OP_W-1:0] alu_opcode;
    logic [D_W-1:0]  alu_out;
    logic            alu_z;
    logic            alu_c;
    logic            alu_v;
    logic            alu_p;
    logic            res_valid;
    logic            res_ready;
    logic [D_W-1:0]  res_data;
    logic [3:0]      res_flags;
    logic [D_W-1:0]  acc;
    logic            busy;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    logic            sticky_clr;
    logic            sticky_c;
    logic            sticky_v;
`endif

    modport slave (
        input  in_valid, in_opcode, in_a, in_b, in_use_acc,
        input  alu_out, alu_z, alu_c, alu_v, alu_p, res_ready,
        output in_ready, alu_a, alu_b, alu_opcode,
        output res_valid, res_data, res_flags, acc, busy
`ifdef ALU_SEQ_STICKY_FLAGS_EN
        , input sticky_clr, output sticky_c, sticky_v
`endif
    );

    modport master (
        output in_valid, in_opcode, in_a, in_b, in_use_acc,
        output alu_out, alu_z, alu_c, alu_v, alu_p, res_ready,
        input  in_ready, alu_a, alu_b, alu_opcode,
        input  res_valid, res_data, res_flags, acc, busy
`ifdef ALU_SEQ_STICKY_FLAGS_EN
        , output sticky_clr, input sticky_c, sticky_v
`endif
    );
endinterface

// File: rtl/alu_4bit_sequencer.sv
// alu_4bit_sequencer: holds ALU operands for SETTLE_CYCLES, captures result/flags into acc; ALU_SEQ_STICKY_FLAGS_EN adds sticky C/V
module alu_4bit_sequencer
    import alu_seq_pkg::*;
#(
    parameter int             SETTLE_CYCLES = 1,
    parameter logic [D_W-1:0] ACC_RESET     = 4'h0
) (
    input logic                  clk,
    input logic                  rst_n,
    alu_4bit_sequencer_if.slave  sif
);
    seq_state_t      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [D_W-1:0]  a_q, a_d, b_q, b_d, data_q, data_d, acc_q, acc_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [3:0]      flags_q, flags_d;
    logic            capture;

    assign capture = (state_q == SETTLE) && (cnt_q == 4'd0);

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            data_q  <= '0;
            flags_q <= '0;
            acc_q   <= ACC_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            data_q  <= data_d;
            flags_q <= flags_d;
            acc_q   <= acc_d;
        end
    end

    // Next state: accept in IDLE, count down in SETTLE, wait for downstream in DONE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        data_d  = data_q;
        flags_d = flags_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: if (sif.in_valid) begin
                op_d    = sif.in_opcode;
                b_d     = sif.in_b;
                a_d     = sif.in_use_acc ? acc_q : sif.in_a;
                cnt_d   = 4'(SETTLE_CYCLES - 1);
                state_d = SETTLE;
            end
            SETTLE: if (capture) begin
                data_d          = sif.alu_out;
                acc_d           = sif.alu_out;
                flags_d[FLAG_Z] = sif.alu_z;
                flags_d[FLAG_C] = sif.alu_c;
                flags_d[FLAG_V] = sif.alu_v;
                flags_d[FLAG_P] = sif.alu_p;
                state_d         = DONE;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            DONE: state_d = sif.res_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    assign sif.in_ready   = state_q == IDLE;
    assign sif.res_valid  = state_q == DONE;
    assign sif.busy       = state_q != IDLE;
    assign sif.alu_a      = a_q;
    assign sif.alu_b      = b_q;
    assign sif.alu_opcode = op_q;
    assign sif.res_data   = data_q;
    assign sif.res_flags  = flags_q;
    assign sif.acc        = acc_q;

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    logic sticky_c_q, sticky_v_q;

    // Sticky carry/overflow accumulate over captures; a clear on the capture cycle drops that capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_c_q <= 1'b0;
            sticky_v_q <= 1'b0;
        end else begin
            sticky_c_q <= sif.sticky_clr ? 1'b0 : sticky_c_q | (capture & sif.alu_c);
            sticky_v_q <= sif.sticky_clr ? 1'b0 : sticky_v_q | (capture & sif.alu_v);
        end
    end

    assign sif.sticky_c = sticky_c_q;
    assign sif.sticky_v = sticky_v_q;
`endif
endmodule
